id_ex_stage: RTL

- ID→EX pipeline register of the 5-stage core.
- Captures the bypassed operands and the decoded control from the ID stage and presents them to EX for one instruction per cycle.
- Owns load-use bubble insertion: it turns the ID stage's load-related hazard flags into a stall request and inserts NOP bubbles.
- Drives the EX-side load flag, write enable and write address back into the ID operand-bypass logic.

---
 rtl/id_ex_stage_pkg.sv | 43 ++++
 rtl/id_ex_stage_sat_counter.sv | 35 +++
 rtl/id_ex_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths and ALU operation encodings for the ID->EX pipeline register.
// Also holds the update-selection type used by the stage.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int FUNCT_W_DEF    = 6;
    localparam int CNT_W_DEF      = 16;
    localparam int SHAMT_W        = 5;
    localparam int MEM_SEL_W      = 4;

    // FUNCT_NOP must stay zero: a cleared EX register must read as a NOP.
    typedef enum logic [5:0] {
        FUNCT_NOP  = 6'd0,
        FUNCT_ADD  = 6'd1,
        FUNCT_ADDU = 6'd2,
        FUNCT_SUB  = 6'd3,
        FUNCT_SUBU = 6'd4,
        FUNCT_AND  = 6'd5,
        FUNCT_OR   = 6'd6,
        FUNCT_XOR  = 6'd7,
        FUNCT_NOR  = 6'd8,
        FUNCT_SLT  = 6'd9,
        FUNCT_SLTU = 6'd10,
        FUNCT_SLL  = 6'd11,
        FUNCT_SRL  = 6'd12,
        FUNCT_SRA  = 6'd13,
        FUNCT_LUI  = 6'd14
    } alu_funct_e;

    typedef enum logic [1:0] {
        UPD_CAPTURE = 2'd0,
        UPD_HOLD    = 2'd1,
        UPD_BUBBLE  = 2'd2
    } upd_sel_e;

    function automatic logic load_use_hazard(input logic valid,
                                             input logic rel_1,
                                             input logic rel_2);
        return valid & (rel_1 | rel_2);
    endfunction

endpackage

// File: rtl/id_ex_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: increment when enabled, stick at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: captures bypassed operands and decoded control,
// inserts load-use bubbles and feeds the EX destination back to ID bypass.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int FUNCT_W    = FUNCT_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_ex,
    input  logic                  stall_id,
    input  logic                  load_related_1,
    input  logic                  load_related_2,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [FUNCT_W-1:0]    id_funct,
    input  logic [DATA_W-1:0]     id_operand_1,
    input  logic [DATA_W-1:0]     id_operand_2,
    input  logic [SHAMT_W-1:0]    id_shamt,
    input  logic                  id_mem_read_flag,
    input  logic                  id_mem_write_flag,
    input  logic                  id_mem_sign_ext,
    input  logic [MEM_SEL_W-1:0]  id_mem_sel,
    input  logic [DATA_W-1:0]     id_mem_write_data,
    input  logic                  id_reg_write_en,
    input  logic [REG_ADDR_W-1:0] id_reg_write_addr,
    input  logic                  id_delay_slot,
    output logic                  load_stall_req,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [FUNCT_W-1:0]    ex_funct,
    output logic [DATA_W-1:0]     ex_operand_1,
    output logic [DATA_W-1:0]     ex_operand_2,
    output logic [SHAMT_W-1:0]    ex_shamt,
    output logic                  ex_mem_read_flag,
    output logic                  ex_mem_write_flag,
    output logic                  ex_mem_sign_ext,
    output logic [MEM_SEL_W-1:0]  ex_mem_sel,
    output logic [DATA_W-1:0]     ex_mem_write_data,
    output logic                  ex_reg_write_en,
    output logic [REG_ADDR_W-1:0] ex_reg_write_addr,
    output logic                  ex_delay_slot,
    output logic                  ex_load_flag,
    output logic [CNT_W-1:0]      load_stall_count
);

    localparam logic [FUNCT_W-1:0] NOP_F = FUNCT_W'(FUNCT_NOP);

    upd_sel_e              upd_sel_s;
    logic                  load_stall_s;

    logic                  valid_q,     valid_d;
    logic [DATA_W-1:0]     pc_q,        pc_d;
    logic [FUNCT_W-1:0]    funct_q,     funct_d;
    logic [DATA_W-1:0]     op1_q,       op1_d;
    logic [DATA_W-1:0]     op2_q,       op2_d;
    logic [SHAMT_W-1:0]    shamt_q,     shamt_d;
    logic                  mem_rd_q,    mem_rd_d;
    logic                  mem_wr_q,    mem_wr_d;
    logic                  sign_ext_q,  sign_ext_d;
    logic [MEM_SEL_W-1:0]  mem_sel_q,   mem_sel_d;
    logic [DATA_W-1:0]     wdata_q,     wdata_d;
    logic                  wen_q,       wen_d;
    logic [REG_ADDR_W-1:0] waddr_q,     waddr_d;
    logic                  dslot_q,     dslot_d;

    assign load_stall_s   = load_use_hazard(id_valid, load_related_1, load_related_2);
    assign load_stall_req = load_stall_s;

    // Update selection: flush beats an EX hold, which beats ID-side bubbles.
    always_comb begin
        upd_sel_s = UPD_CAPTURE;
        if (flush) begin
            upd_sel_s = UPD_BUBBLE;
        end else if (stall_ex) begin
            upd_sel_s = UPD_HOLD;
        end else if (stall_id || load_stall_s) begin
            upd_sel_s = UPD_BUBBLE;
        end else begin
            upd_sel_s = UPD_CAPTURE;
        end
    end

    // Next EX contents for the selected update; side-effect flags qualified by id_valid.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        funct_d    = funct_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        shamt_d    = shamt_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        sign_ext_d = sign_ext_q;
        mem_sel_d  = mem_sel_q;
        wdata_d    = wdata_q;
        wen_d      = wen_q;
        waddr_d    = waddr_q;
        dslot_d    = dslot_q;
        case (upd_sel_s)
            UPD_CAPTURE: begin
                valid_d    = id_valid;
                pc_d       = id_pc;
                funct_d    = id_funct;
                op1_d      = id_operand_1;
                op2_d      = id_operand_2;
                shamt_d    = id_shamt;
                mem_rd_d   = id_mem_read_flag & id_valid;
                mem_wr_d   = id_mem_write_flag & id_valid;
                sign_ext_d = id_mem_sign_ext;
                mem_sel_d  = id_mem_sel;
                wdata_d    = id_mem_write_data;
                wen_d      = id_reg_write_en & id_valid;
                waddr_d    = id_reg_write_addr;
                dslot_d    = id_delay_slot;
            end
            UPD_HOLD: begin
                valid_d    = valid_q;
                pc_d       = pc_q;
            end
            UPD_BUBBLE: begin
                valid_d    = 1'b0;
                pc_d       = {DATA_W{1'b0}};
                funct_d    = NOP_F;
                op1_d      = {DATA_W{1'b0}};
                op2_d      = {DATA_W{1'b0}};
                shamt_d    = {SHAMT_W{1'b0}};
                mem_rd_d   = 1'b0;
                mem_wr_d   = 1'b0;
                sign_ext_d = 1'b0;
                mem_sel_d  = {MEM_SEL_W{1'b0}};
                wdata_d    = {DATA_W{1'b0}};
                wen_d      = 1'b0;
                waddr_d    = {REG_ADDR_W{1'b0}};
                dslot_d    = 1'b0;
            end
            default: begin
                valid_d    = 1'b0;
                funct_d    = NOP_F;
                mem_rd_d   = 1'b0;
                mem_wr_d   = 1'b0;
                wen_d      = 1'b0;
                dslot_d    = 1'b0;
            end
        endcase
    end

    // EX pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= {DATA_W{1'b0}};
            funct_q    <= NOP_F;
            op1_q      <= {DATA_W{1'b0}};
            op2_q      <= {DATA_W{1'b0}};
            shamt_q    <= {SHAMT_W{1'b0}};
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            sign_ext_q <= 1'b0;
            mem_sel_q  <= {MEM_SEL_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            wen_q      <= 1'b0;
            waddr_q    <= {REG_ADDR_W{1'b0}};
            dslot_q    <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            funct_q    <= funct_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            shamt_q    <= shamt_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            sign_ext_q <= sign_ext_d;
            mem_sel_q  <= mem_sel_d;
            wdata_q    <= wdata_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            dslot_q    <= dslot_d;
        end
    end

    // Only bubbles that actually enter EX are counted (not those masked by a hold or flush).
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (load_stall_s & ~stall_ex & ~flush),
        .count (load_stall_count)
    );

    assign ex_valid          = valid_q;
    assign ex_pc             = pc_q;
    assign ex_funct          = funct_q;
    assign ex_operand_1      = op1_q;
    assign ex_operand_2      = op2_q;
    assign ex_shamt          = shamt_q;
    assign ex_mem_read_flag  = mem_rd_q;
    assign ex_mem_write_flag = mem_wr_q;
    assign ex_mem_sign_ext   = sign_ext_q;
    assign ex_mem_sel        = mem_sel_q;
    assign ex_mem_write_data = wdata_q;
    assign ex_reg_write_en   = wen_q;
    assign ex_reg_write_addr = waddr_q;
    assign ex_delay_slot     = dslot_q;
    assign ex_load_flag      = valid_q & mem_rd_q;

endmodule
